// File: rtl/ldst_engine.sv
// ldst_engine: decoded load/store sequencer for the memory stage.
// Single LDR/STR (byte/half/word, lane strobes) and LDM/STM with base writeback.
module ldst_engine #(
  parameter int NREGS  = 16,
  parameter int REGW   = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_multi,
  input  logic              in_load,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic              in_up,
  input  logic              in_pre,
  input  logic              in_wb,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic [31:0]       in_sdata,
  input  logic [REGW-1:0]   in_rd,
  input  logic [REGW-1:0]   in_rn,
  input  logic [NREGS-1:0]  in_list,
  output logic [ADDR_W-1:0] busaddr,
  output logic              rd_req,
  output logic              wr_req,
  output logic [3:0]        wr_be,
  output logic [31:0]       wr_data,
  input  logic [31:0]       rd_data,
  input  logic              rw_wait,
  output logic [REGW-1:0]   st_read,
  input  logic [31:0]       st_data,
  output logic              out_write_reg,
  output logic [REGW-1:0]   out_write_num,
  output logic [31:0]       out_write_data,
  output logic              done,
  output logic              fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [REGW:0] popcount(input logic [NREGS-1:0] v);
    logic [REGW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + {{REGW{1'b0}}, v[i]};
    return c;
  endfunction

  // Rotate right by the byte lane, then trim and extend to the access size.
  function automatic logic [31:0] load_format(input logic [31:0] d, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [5:0]  sh;
    logic [31:0] r;
    sh = {1'b0, lane, 3'b000};
    r  = (d >> sh) | (d << (6'd32 - sh));
    case (size)
      2'b00:   load_format = {{24{sgn & r[7]}}, r[7:0]};
      2'b01:   load_format = {{16{sgn & r[15]}}, r[15:0]};
      default: load_format = r;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic              wout_q, wout_d;
  logic [REGW-1:0]   wnum_q, wnum_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic              load_q, load_d;
  logic              multi_q, multi_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        size_q, size_d;
  logic [REGW-1:0]   rd_q, rd_d;
  logic [REGW-1:0]   rn_q, rn_d;
  logic [NREGS-1:0]  list_q, list_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [ADDR_W-1:0] wbval_q, wbval_d;
  logic              wbdo_q, wbdo_d;
  logic [31:0]       sdata_q, sdata_d;

  logic [REGW-1:0]   idx;
  logic [NREGS-1:0]  list_next;
  logic [ADDR_W-1:0] single_addr, single_ea, span, multi_start, multi_final;
  logic [ADDR_W-1:0] acc_ea;
  logic              acc_fault, acc_wbdo, xfer;
  logic [31:0]       st_word;

  // Lowest remaining list bit is the current beat (ascending addresses).
  always_comb begin
    idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (list_q[i]) idx = REGW'(i);
    end
    list_next      = list_q;
    list_next[idx] = 1'b0;
  end

  always_comb begin
    single_addr = in_up ? in_base + in_offset : in_base - in_offset;
    single_ea   = in_pre ? single_addr : in_base;
    span        = ADDR_W'(popcount(in_list)) << 2;
    case ({in_up, in_pre})
      2'b10:   multi_start = in_base;
      2'b11:   multi_start = in_base + ADDR_W'(4);
      2'b00:   multi_start = in_base - span + ADDR_W'(4);
      default: multi_start = in_base - span;
    endcase
    multi_final = in_up ? in_base + span : in_base - span;
    acc_ea      = in_multi ? multi_start : single_ea;
    acc_fault   = in_multi ? (multi_start[1:0] != 2'b00)
                           : (in_size == 2'b01) && single_ea[0];
    // A load that overwrites the base register wins over writeback.
    acc_wbdo    = in_multi ? in_wb & ~(in_load & in_list[in_rn])
                           : (in_wb | ~in_pre) & ~(in_load & (in_rd == in_rn));
  end

  always_comb begin
    state_d = state_q;
    wout_d  = 1'b0;
    wnum_d  = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    load_d  = load_q;
    multi_d = multi_q;
    sgn_d   = sgn_q;
    size_d  = size_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    list_d  = list_q;
    ea_d    = ea_q;
    wbval_d = wbval_q;
    wbdo_d  = wbdo_q;
    sdata_d = sdata_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          load_d  = in_load;
          multi_d = in_multi;
          sgn_d   = in_signed;
          size_d  = in_multi ? 2'b10 : in_size;
          rd_d    = in_rd;
          rn_d    = in_rn;
          list_d  = in_list;
          ea_d    = acc_ea;
          wbval_d = in_multi ? multi_final : single_addr;
          wbdo_d  = acc_wbdo;
          sdata_d = in_sdata;
          if (acc_fault) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (in_multi && in_list == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            wout_d  = acc_wbdo;
            wnum_d  = acc_wbdo ? in_rn : '0;
            wdata_d = acc_wbdo ? multi_final[31:0] : '0;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (!rw_wait) begin
          if (load_q) begin
            wout_d  = 1'b1;
            wnum_d  = multi_q ? idx : rd_q;
            wdata_d = load_format(rd_data, ea_q[1:0], size_q, sgn_q);
          end
          list_d = list_next;
          ea_d   = ea_q + ADDR_W'(4);
          if (!multi_q || list_next == '0) begin
            if (load_q && wbdo_q) begin
              state_d = S_WB;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              if (wbdo_q) begin
                wout_d  = 1'b1;
                wnum_d  = rn_q;
                wdata_d = wbval_q[31:0];
              end
            end
          end
        end
      end
      S_WB: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        wout_d  = 1'b1;
        wnum_d  = rn_q;
        wdata_d = wbval_q[31:0];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= S_IDLE;
      wout_q  <= 1'b0;
      wnum_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wout_q  <= wout_d;
      wnum_q  <= wnum_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  // Request context is only observed while the state register says XFER.
  always_ff @(posedge clk) begin
    load_q  <= load_d;
    multi_q <= multi_d;
    sgn_q   <= sgn_d;
    size_q  <= size_d;
    rd_q    <= rd_d;
    rn_q    <= rn_d;
    list_q  <= list_d;
    ea_q    <= ea_d;
    wbval_q <= wbval_d;
    wbdo_q  <= wbdo_d;
    sdata_q <= sdata_d;
  end

  assign xfer     = (state_q == S_XFER);
  assign in_ready = (state_q == S_IDLE);
  assign busaddr  = xfer ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
  assign rd_req   = xfer & load_q;
  assign wr_req   = xfer & ~load_q;
  assign st_read  = (wr_req & multi_q) ? idx : '0;
  assign st_word  = multi_q ? st_data : sdata_q;

  always_comb begin
    wr_data = '0;
    wr_be   = '0;
    if (wr_req) begin
      case (size_q)
        2'b00: begin
          wr_data = {4{st_word[7:0]}};
          wr_be   = 4'b0001 << ea_q[1:0];
        end
        2'b01: begin
          wr_data = {2{st_word[15:0]}};
          wr_be   = ea_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wr_data = st_word;
          wr_be   = 4'b1111;
        end
      endcase
    end
  end

  assign out_write_reg  = wout_q;
  assign out_write_num  = wnum_q;
  assign out_write_data = wdata_q;
  assign done           = done_q;
  assign fault          = fault_q;

endmodule

// File: tb/tb_ldst_engine.sv
// Bench for ldst_engine: directed scenarios plus randomized requests against
// an address/lane-rule reference model with a memory array and random bus waits.
module tb_ldst_engine;

  logic        clk = 1'b0;
  logic        Nrst;
  logic        in_valid, in_ready, in_multi, in_load, in_signed, in_up, in_pre, in_wb;
  logic [1:0]  in_size;
  logic [31:0] in_base, in_offset, in_sdata;
  logic [3:0]  in_rd, in_rn;
  logic [15:0] in_list;
  logic [31:0] busaddr, wr_data, rd_data, st_data, out_write_data;
  logic        rd_req, wr_req, rw_wait, out_write_reg, done, fault;
  logic [3:0]  wr_be, st_read, out_write_num;

  always #5 clk = ~clk;

  ldst_engine #(.NREGS(16), .REGW(4), .ADDR_W(32)) dut (
    .clk(clk), .Nrst(Nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_multi(in_multi), .in_load(in_load), .in_size(in_size), .in_signed(in_signed),
    .in_up(in_up), .in_pre(in_pre), .in_wb(in_wb), .in_base(in_base),
    .in_offset(in_offset), .in_sdata(in_sdata), .in_rd(in_rd), .in_rn(in_rn),
    .in_list(in_list), .busaddr(busaddr), .rd_req(rd_req), .wr_req(wr_req),
    .wr_be(wr_be), .wr_data(wr_data), .rd_data(rd_data), .rw_wait(rw_wait),
    .st_read(st_read), .st_data(st_data), .out_write_reg(out_write_reg),
    .out_write_num(out_write_num), .out_write_data(out_write_data),
    .done(done), .fault(fault)
  );

  typedef struct packed {
    logic        multi, load;
    logic [1:0]  size;
    logic        sgn, up, pre, wb;
    logic [31:0] base, offset, sdata;
    logic [3:0]  rd, rn;
    logic [15:0] list;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        rd, wr;
    logic [3:0]  be;
    logic [31:0] data;
    logic        wt;
  } bus_t;

  typedef struct {
    int          cyc;
    logic [3:0]  num;
    logic [31:0] data;
  } wr_t;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] rf [16];
  logic [31:0] mem [logic [31:0]];
  bus_t        blog[$], eb[$];
  wr_t         wlog[$], ew[$];
  int          done_cyc, wait_mode;
  logic        fault_obs, use_fixed, exp_fault, exp_wbdo;
  logic [31:0] fixed_rdata;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    logic [31:0] k;
    k = a & 32'hFFFF_FFFC;
    if (mem.exists(k)) return mem[k];
    return (k * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pickwait();
    return (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
  endfunction

  // Issue one request and act as bus slave / regfile until done or budget.
  task automatic run(input req_t r, input int maxc);
    int          cyc, wleft;
    logic [31:0] w;
    blog.delete(); wlog.delete(); done_cyc = -1; fault_obs = 1'b0;
    in_multi = r.multi; in_load = r.load; in_size = r.size; in_signed = r.sgn;
    in_up = r.up; in_pre = r.pre; in_wb = r.wb; in_base = r.base; in_offset = r.offset;
    in_sdata = r.sdata; in_rd = r.rd; in_rn = r.rn; in_list = r.list;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    wleft = pickwait();
    while (done_cyc < 0 && cyc <= maxc) begin
      st_data = rf[st_read];
      #1;
      if (rd_req || wr_req) begin
        rw_wait = (wleft > 0);
        rd_data = rw_wait ? $urandom : (use_fixed ? fixed_rdata : memrd(busaddr));
        blog.push_back('{cyc, busaddr, rd_req, wr_req, wr_be, wr_data, rw_wait});
        if (wleft > 0) wleft--;
        else begin
          wleft = pickwait();
          if (wr_req) begin
            w = memrd(busaddr);
            for (int b = 0; b < 4; b++) if (wr_be[b]) w[8*b +: 8] = wr_data[8*b +: 8];
            mem[busaddr] = w;
          end
        end
      end else begin
        rw_wait = 1'($urandom_range(0, 1));
        rd_data = $urandom;
      end
      if (out_write_reg) wlog.push_back('{cyc, out_write_num, out_write_data});
      if (done) begin done_cyc = cyc; fault_obs = fault; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic model(input req_t r);
    logic [31:0] addr, ea, w, v, start, span, fin;
    logic [63:0] v64;
    logic [3:0]  be;
    int          sh, k;
    eb.delete(); ew.delete();
    if (!r.multi) begin
      addr = r.up ? r.base + r.offset : r.base - r.offset;
      ea = r.pre ? addr : r.base;
      sh = int'(ea % 4);
      exp_fault = (r.size == 2'd1) && (ea % 2 == 1);
      exp_wbdo = (r.wb || !r.pre) && !(r.load && r.rd == r.rn);
      if (exp_fault) return;
      if (r.load) begin
        w = memrd(ea);
        v64 = {w, w} >> (8 * sh);
        v = v64[31:0];
        if (r.size == 2'd0) begin v = v % 256; if (r.sgn && v >= 128) v = v - 256; end
        else if (r.size == 2'd1) begin v = v % 65536; if (r.sgn && v >= 32768) v = v - 65536; end
        eb.push_back('{0, ea - sh, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0});
        ew.push_back('{0, r.rd, v});
      end else begin
        if (r.size == 2'd0) begin v = (r.sdata % 256) * 32'h0101_0101; be = 4'b0001 << sh; end
        else if (r.size == 2'd1) begin v = (r.sdata % 65536) * 32'h0001_0001; be = (sh >= 2) ? 4'hC : 4'h3; end
        else begin v = r.sdata; be = 4'hF; end
        eb.push_back('{0, ea - sh, 1'b0, 1'b1, be, v, 1'b0});
      end
      if (exp_wbdo) ew.push_back('{0, r.rn, addr});
    end else begin
      span = 4 * $countones(r.list);
      if (r.up) start = r.pre ? r.base + 4 : r.base;
      else      start = r.pre ? r.base - span : r.base - span + 4;
      fin = r.up ? r.base + span : r.base - span;
      exp_fault = (start % 4 != 0);
      exp_wbdo = r.wb && !(r.load && r.list[r.rn]);
      if (exp_fault) return;
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (r.list[i]) begin
          addr = start + 4 * k;
          k++;
          if (r.load) begin
            eb.push_back('{0, addr, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0});
            ew.push_back('{0, 4'(i), memrd(addr)});
          end else begin
            eb.push_back('{0, addr, 1'b0, 1'b1, 4'hF, rf[i], 1'b0});
          end
        end
      end
      if (exp_wbdo) ew.push_back('{0, r.rn, fin});
    end
  endtask

  task automatic test_reset();
    logic [113:0] snap;
    Nrst = 1'b0; in_valid = 1'b0; in_multi = 1'b0; in_load = 1'b0; in_size = 2'd0;
    in_signed = 1'b0; in_up = 1'b0; in_pre = 1'b0; in_wb = 1'b0; in_base = '0;
    in_offset = '0; in_sdata = '0; in_rd = '0; in_rn = '0; in_list = '0;
    rd_data = '0; rw_wait = 1'b0; st_data = '0;
    #2;
    snap = {in_ready, rd_req, wr_req, busaddr, wr_be, wr_data, st_read, out_write_reg,
            out_write_num, out_write_data, done, fault};
    n_tests++;
    if (snap !== {1'b1, 113'd0}) begin
      n_fail++; $display("FAIL reset_outputs: got %h want %h", snap, {1'b1, 113'd0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); Nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ldrb_signed();
    req_t r;
    r = '0; r.load = 1; r.size = 2'd0; r.sgn = 1; r.up = 1; r.pre = 1;
    r.base = 32'h1000; r.offset = 32'd3; r.rd = 4'd6; r.rn = 4'd1;
    use_fixed = 1'b1; fixed_rdata = 32'h80FF_0000; wait_mode = 0;
    run(r, 50);
    n_tests++;
    if (blog.size() != 1 || blog[0].addr !== 32'h1000 || blog[0].cyc != 1 || blog[0].rd !== 1'b1) begin
      n_fail++; $display("FAIL ldrb_bus: beats=%0d addr=%h cyc=%0d, want 1 read at 00001000 cyc 1",
                         blog.size(), blog[0].addr, blog[0].cyc);
    end
    n_tests++;
    if (wlog.size() != 1 || wlog[0].num !== 4'd6 || wlog[0].data !== 32'hFFFF_FF80 || wlog[0].cyc != 2) begin
      n_fail++; $display("FAIL ldrb_write: n=%0d r%0d=%h cyc=%0d, want r6=ffffff80 cyc 2",
                         wlog.size(), wlog[0].num, wlog[0].data, wlog[0].cyc);
    end
    n_tests++;
    if (done_cyc != 2 || fault_obs !== 1'b0) begin
      n_fail++; $display("FAIL ldrb_done: cyc=%0d fault=%b, want cyc 2 fault 0", done_cyc, fault_obs);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ldrb_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_strh_wait();
    req_t r;
    r = '0; r.size = 2'd1; r.up = 1; r.pre = 1; r.base = 32'h2000; r.offset = 32'd2;
    r.sdata = 32'h1234_ABCD; r.rd = 4'd2; r.rn = 4'd3;
    use_fixed = 1'b0; wait_mode = 3;
    run(r, 50);
    n_tests++;
    if (blog.size() != 4) begin n_fail++; $display("FAIL strh_beats: got %0d want 4", blog.size()); end
    foreach (blog[k]) begin
      n_tests++;
      if (blog[k].addr !== 32'h2000 || blog[k].wr !== 1'b1 || blog[k].be !== 4'b1100 ||
          blog[k].data !== 32'hABCD_ABCD || blog[k].cyc != k + 1) begin
        n_fail++; $display("FAIL strh_hold[%0d]: addr=%h be=%b data=%h cyc=%0d, want 00002000 1100 abcdabcd cyc %0d",
                           k, blog[k].addr, blog[k].be, blog[k].data, blog[k].cyc, k + 1);
      end
    end
    n_tests++;
    if (done_cyc != 5 || wlog.size() != 0) begin
      n_fail++; $display("FAIL strh_done: cyc=%0d writes=%0d, want cyc 5 writes 0", done_cyc, wlog.size());
    end
  endtask

  task automatic test_ldr_post();
    req_t r;
    r = '0; r.load = 1; r.size = 2'd2; r.up = 1; r.pre = 0; r.base = 32'h3001;
    r.offset = 32'd8; r.rd = 4'd2; r.rn = 4'd5;
    use_fixed = 1'b1; fixed_rdata = 32'h1122_3344; wait_mode = 0;
    run(r, 50);
    n_tests++;
    if (blog.size() != 1 || blog[0].addr !== 32'h3000) begin
      n_fail++; $display("FAIL ldr_post_bus: beats=%0d addr=%h, want 1 at 00003000", blog.size(), blog[0].addr);
    end
    n_tests++;
    if (wlog.size() != 2 || wlog[0].num !== 4'd2 || wlog[0].data !== 32'h4411_2233 || wlog[0].cyc != 2) begin
      n_fail++; $display("FAIL ldr_post_rd: n=%0d r%0d=%h cyc=%0d, want r2=44112233 cyc 2",
                         wlog.size(), wlog[0].num, wlog[0].data, wlog[0].cyc);
    end
    n_tests++;
    if (wlog[1].num !== 4'd5 || wlog[1].data !== 32'h3009 || wlog[1].cyc != 3 || done_cyc != 3) begin
      n_fail++; $display("FAIL ldr_post_wb: r%0d=%h cyc=%0d done=%0d, want r5=00003009 cyc 3 done 3",
                         wlog[1].num, wlog[1].data, wlog[1].cyc, done_cyc);
    end
  endtask

  task automatic test_ldmdb();
    req_t        r;
    logic [31:0] ea [3];
    logic [3:0]  num [3];
    ea = '{32'h4004, 32'h4008, 32'h400C};
    num = '{4'd1, 4'd3, 4'd7};
    mem[32'h4004] = 32'hAAAA_0001; mem[32'h4008] = 32'hBBBB_0003; mem[32'h400C] = 32'hCCCC_0007;
    r = '0; r.multi = 1; r.load = 1; r.up = 0; r.pre = 1; r.wb = 1; r.base = 32'h4010;
    r.rn = 4'd9; r.list = 16'h008A;
    use_fixed = 1'b0; wait_mode = 0;
    run(r, 50);
    n_tests++;
    if (blog.size() != 3 || wlog.size() != 4 || done_cyc != 5) begin
      n_fail++; $display("FAIL ldmdb_counts: beats=%0d writes=%0d done=%0d, want 3 4 5",
                         blog.size(), wlog.size(), done_cyc);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (blog[k].addr !== ea[k] || wlog[k].num !== num[k] || wlog[k].data !== memrd(ea[k])) begin
        n_fail++; $display("FAIL ldmdb_beat[%0d]: addr=%h r%0d=%h, want %h r%0d=%h", k, blog[k].addr,
                           wlog[k].num, wlog[k].data, ea[k], num[k], memrd(ea[k]));
      end
    end
    n_tests++;
    if (wlog[3].num !== 4'd9 || wlog[3].data !== 32'h4004) begin
      n_fail++; $display("FAIL ldmdb_wb: r%0d=%h want r9=00004004", wlog[3].num, wlog[3].data);
    end
  endtask

  task automatic test_ldrh_fault();
    req_t r;
    r = '0; r.load = 1; r.size = 2'd1; r.up = 1; r.pre = 1; r.wb = 1;
    r.base = 32'h5001; r.rd = 4'd4; r.rn = 4'd8;
    use_fixed = 1'b0; wait_mode = 0;
    run(r, 50);
    n_tests++;
    if (blog.size() != 0 || wlog.size() != 0) begin
      n_fail++; $display("FAIL ldrh_fault_quiet: beats=%0d writes=%0d want 0 0", blog.size(), wlog.size());
    end
    n_tests++;
    if (done_cyc != 1 || fault_obs !== 1'b1) begin
      n_fail++; $display("FAIL ldrh_fault_done: cyc=%0d fault=%b want cyc 1 fault 1", done_cyc, fault_obs);
    end
  endtask

  task automatic test_stmia_reset();
    logic         ok;
    logic [113:0] snap;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    in_multi = 1'b1; in_load = 1'b0; in_size = 2'd2; in_up = 1'b1; in_pre = 1'b0; in_wb = 1'b1;
    in_base = 32'h6000; in_rn = 4'd12; in_list = 16'h0055;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    st_data = rf[st_read]; rw_wait = 1'b0; #1;
    n_tests++;
    if (wr_req !== 1'b1 || busaddr !== 32'h6000 || wr_data !== rf[0] || wr_be !== 4'hF) begin
      n_fail++; $display("FAIL stmia_beat1: req=%b addr=%h data=%h be=%b want 1 00006000 %h 1111",
                         wr_req, busaddr, wr_data, wr_be, rf[0]);
    end
    @(posedge clk); #1;
    st_data = rf[st_read]; rw_wait = 1'b1; #1;
    n_tests++;
    if (busaddr !== 32'h6004 || wr_data !== rf[2]) begin
      n_fail++; $display("FAIL stmia_beat2: addr=%h data=%h want 00006004 %h", busaddr, wr_data, rf[2]);
    end
    Nrst = 1'b0; #1;
    snap = {in_ready, rd_req, wr_req, busaddr, wr_be, wr_data, st_read, out_write_reg,
            out_write_num, out_write_data, done, fault};
    n_tests++;
    if (snap !== {1'b1, 113'd0}) begin
      n_fail++; $display("FAIL stmia_async_reset: got %h want %h", snap, {1'b1, 113'd0});
    end
    @(negedge clk); Nrst = 1'b1; rw_wait = 1'b0; ok = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      st_data = rf[st_read];
      if (rd_req || wr_req || out_write_reg || done || !in_ready) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stmia_after_reset: activity seen, want none"); end
  endtask

  task automatic test_random();
    req_t r;
    bus_t cb[$];
    int   exp_done;
    use_fixed = 1'b0; wait_mode = -1;
    for (int it = 0; it < 40; it++) begin
      r.multi = ($urandom_range(0, 2) == 0);
      r.load = 1'($urandom_range(0, 1)); r.size = 2'($urandom_range(0, 2));
      r.sgn = 1'($urandom_range(0, 1)); r.up = 1'($urandom_range(0, 1));
      r.pre = 1'($urandom_range(0, 1)); r.wb = 1'($urandom_range(0, 1));
      r.base = $urandom;
      if (r.multi && $urandom_range(0, 7) != 0) r.base[1:0] = 2'b00;
      r.offset = $urandom_range(0, 64); r.sdata = $urandom;
      r.rd = 4'($urandom); r.rn = 4'($urandom); r.list = 16'($urandom);
      if ($urandom_range(0, 5) == 0) r.list = '0;
      else if ($urandom_range(0, 1) == 0) r.list = r.list & 16'($urandom);
      model(r);
      run(r, 200);
      cb.delete();
      foreach (blog[k]) if (!blog[k].wt) cb.push_back(blog[k]);
      n_tests++;
      if (fault_obs !== exp_fault) begin
        n_fail++; $display("FAIL rand%0d_fault: got %b want %b", it, fault_obs, exp_fault);
      end
      n_tests++;
      if (cb.size() != eb.size()) begin
        n_fail++; $display("FAIL rand%0d_beats: got %0d want %0d", it, cb.size(), eb.size());
      end
      foreach (eb[k]) begin
        if (k < cb.size()) begin
          n_tests++;
          if ({cb[k].addr, cb[k].rd, cb[k].wr, cb[k].be, cb[k].data} !==
              {eb[k].addr, eb[k].rd, eb[k].wr, eb[k].be, eb[k].data}) begin
            n_fail++; $display("FAIL rand%0d_beat%0d: addr=%h rd=%b wr=%b be=%b data=%h want %h %b %b %b %h",
                               it, k, cb[k].addr, cb[k].rd, cb[k].wr, cb[k].be, cb[k].data,
                               eb[k].addr, eb[k].rd, eb[k].wr, eb[k].be, eb[k].data);
          end
          if (r.load && k < wlog.size()) begin
            n_tests++;
            if (wlog[k].cyc != cb[k].cyc + 1) begin
              n_fail++; $display("FAIL rand%0d_wtime%0d: got cyc %0d want %0d", it, k, wlog[k].cyc, cb[k].cyc + 1);
            end
          end
        end
      end
      n_tests++;
      if (wlog.size() != ew.size()) begin
        n_fail++; $display("FAIL rand%0d_writes: got %0d want %0d", it, wlog.size(), ew.size());
      end
      foreach (ew[k]) begin
        if (k < wlog.size()) begin
          n_tests++;
          if (wlog[k].num !== ew[k].num || wlog[k].data !== ew[k].data) begin
            n_fail++; $display("FAIL rand%0d_write%0d: r%0d=%h want r%0d=%h", it, k,
                               wlog[k].num, wlog[k].data, ew[k].num, ew[k].data);
          end
        end
      end
      if (exp_fault || eb.size() == 0) exp_done = 1;
      else if (cb.size() == 0) exp_done = -2;
      else exp_done = cb[cb.size()-1].cyc + 1 + ((r.load && exp_wbdo) ? 1 : 0);
      n_tests++;
      if (done_cyc != exp_done || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_done: cyc=%0d ready=%b want cyc %0d ready 1", it, done_cyc, in_ready, exp_done);
      end
      foreach (wlog[k]) rf[wlog[k].num] = wlog[k].data;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    use_fixed = 1'b0; fixed_rdata = '0; wait_mode = 0;
    test_reset();
    test_ldrb_signed();
    test_strh_wait();
    test_ldr_post();
    test_ldmdb();
    test_ldrh_fault();
    test_random();
    test_stmia_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ldst_engine.md
Name: ldst_engine

Overview:
Parametrised load/store sequencer for the memory stage, replacing the insn-decoding memory logic with a decoded-request interface. Performs single LDR/STR in byte, halfword (signed/unsigned) and word sizes, with byte-lane strobes. Also sequences LDM/STM over a parametrised register list in ascending-address order, and writes back the base. Sits between the execute stage, the regfile read/write ports and the shared memory bus.

Parameters:
NREGS, 16, register-list width and number of architectural registers
REGW, 4, register-number width (clog2 of NREGS)
ADDR_W, 32, address and data width (multiple of 32; lane logic acts on the low 32 bits)

Ports:
clk  in  1  clock
Nrst  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  engine idle, will accept
in_multi  in  1  1 = LDM/STM, 0 = single transfer
in_load  in  1  1 = load, 0 = store
in_size  in  2  00 byte, 01 half, 10 word (single only)
in_signed  in  1  sign-extend byte/half loads
in_up  in  1  add (1) or subtract (0) offset
in_pre  in  1  pre-index (1) or post-index (0)
in_wb  in  1  write back base
in_base  in  ADDR_W  base register value
in_offset  in  ADDR_W  single-transfer offset
in_sdata  in  32  single store data
in_rd  in  REGW  single destination/source register
in_rn  in  REGW  base register number
in_list  in  NREGS  LDM/STM register list
busaddr  out  ADDR_W  word-aligned bus address
rd_req  out  1  bus read request
wr_req  out  1  bus write request
wr_be  out  4  byte-lane write enables
wr_data  out  32  store data, lane-replicated
rd_data  in  32  bus read data, valid when req and !rw_wait
rw_wait  in  1  bus not done this cycle
st_read  out  REGW  regfile read select (STM)
st_data  in  32  regfile read data, combinational from st_read
out_write_reg  out  1  regfile write strobe
out_write_num  out  REGW  regfile write register
out_write_data  out  32  regfile write data
done  out  1  one-cycle pulse: request fully retired
fault  out  1  one-cycle pulse with done: alignment fault

Behaviour:
- Reset (async, Nrst=0): state IDLE. Outputs: in_ready=1, all other outputs 0. Any in-flight transfer is abandoned; no write is emitted after release.
- States: IDLE, XFER, WB, DONE. Accept on in_valid & in_ready; latch all inputs. in_ready=1 only in IDLE.
- Single: addr = in_up ? base+offset : base-offset. Effective address ea = in_pre ? addr : base. Post-index forces writeback.
- Multiple: n = popcount(list). Start address: IA base, IB base+4, DA base-4n+4, DB base-4n. Final base = base ± 4n. Lowest set bit goes to the lowest address.
- Fault: a half at ea[0]=1, or a multiple whose start[1:0]!=0, is a fault. No bus request, no register write. Next cycle: done=1 and fault=1, then IDLE. A word single at a misaligned address is legal (rotate).
- XFER: registered bus request is asserted from the cycle after accept. busaddr={ea[ADDR_W-1:2],2'b0}. rd_req=in_load, wr_req=!in_load. Request, address, data and be are held stable while rw_wait=1. A beat completes in the cycle with req=1 & rw_wait=0.
- Load data: rotate rd_data right by 8*ea[1:0], then take the low 8/16/32 bits. Byte/half are zero- or sign-extended per in_signed.
- Store lanes: byte: wr_data={4{b}}, wr_be=1<<ea[1:0]. Half: {2{h}}, be=ea[1]?1100:0011. Word: wr_data=data, be=1111.
- Load result: out_write_reg pulses in the cycle after completion, with num=rd (or list index for multiples).
- Multiple: one beat per set bit. The next beat's request is issued in the cycle after the previous completes, overlapping its regfile write. For STM, st_read=current index in the request cycle; st_data is captured into wr_data there.
- WB: out_write_reg for rn with the final base (single: addr). Occurs one cycle after the last load write, or after the store completion. It is skipped if the load wrote rn. An empty list performs no bus cycles; WB (if enabled) writes the unchanged base.
- done: pulses with the final register write, or on the cycle after store completion if there is no WB. Then IDLE; a new request can be accepted the cycle after done.
- Minimum latency: single load, no wait, no wb: accept t0, req t1, write+done t2.

Test Plan:
- Single LDRB signed, base 0x1000, offset 3, pre, up, rd_data 0x80FF_0000, no wait -> busaddr 0x1000 at t1; r[rd]=0xFFFF_FF80 at t2; done at t2.
- STRH, ea 0x2002, data 0x1234_ABCD, rw_wait high 3 cycles -> wr_be=1100, wr_data=0xABCD_ABCD held 4 cycles; done the cycle after the wait drops.
- LDR word, ea 0x3001, post-index, offset 8 -> rotated word written to rd, then base+8 written to rn the next cycle; done with the rn write.
- LDMDB, base 0x4010, list {r1,r3,r7}, wb -> addresses 0x4004, 0x4008, 0x400C loading r1, r3, r7 in order; rn=0x4004.
- LDRH at 0x5001 -> no rd_req ever; done=fault=1 at t1; no out_write_reg.
- STMIA with 4 registers, Nrst pulsed low during beat 2 -> all outputs 0 immediately, in_ready=1; no further bus request or write after release.
